niosii_timer_mch: RTL and testbench
===================================

NIOSII_TIMER_MCH -- requirements
Module: niosii_timer_mch

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent timer channels (1..4).
REQ-002 SHALL have parameter CNT_W, default 32, counter width per channel (17..32).
REQ-003 SHALL have parameter PRE_W, default 8, prescaler width per channel (1..16).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port address  input  5  [4:3] channel select, [2:0] register offset.
REQ-007 SHALL have port chipselect  input  1  Avalon-MM slave select.
REQ-008 SHALL have port write_n  input  1  active-low write strobe.
REQ-009 SHALL have port writedata  input  16  write data.
REQ-010 SHALL have port readdata  output  16  registered read data.
REQ-011 SHALL have port irq  output  1  combined level interrupt.

Function
REQ-012 SHALL use this per-channel register map: 0 STATUS {RUN[1], TO[0]}; 1 CONTROL {STOP[3], START[2], CONT[1], ITO[0]}; 2 PERIOD_L; 3 PERIOD_H (bits CNT_W-17:0 used); 4 SNAP_L; 5 SNAP_H; 6 PRESCALE (PRE_W bits); 7 IRQ_PEND (read-only, bit n = channel n TO & ITO; identical at every channel).
REQ-013 SHALL ignore writes and return 0 on reads to channels >= NUM_CH; unused register bits SHALL read 0.
REQ-014 SHALL register readdata: value of the addressed register at edge N appears on readdata after edge N (1-cycle latency), no chipselect qualification on reads.
REQ-015 SHALL store only ITO and CONT in CONTROL; START and STOP are write-only pulses reading 0.
REQ-016 SHALL set RUN on a CONTROL write with START=1 and clear RUN with STOP=1; STOP SHALL win when both are set.
REQ-017 SHALL generate a tick per running channel every PRESCALE+1 clocks; prescale count SHALL restart at 0 on START, on PRESCALE write, and on period write.
REQ-018 SHALL decrement the counter by 1 on each tick; on a tick with counter == 0 it SHALL reload the period, set TO, and clear RUN if CONT=0.
REQ-019 SHALL, on PERIOD_L or PERIOD_H write, clear RUN and load the counter with the new period on the following clock.
REQ-020 SHALL, on a write to SNAP_L or SNAP_H, capture the current counter into the snapshot register on the same edge.
REQ-021 SHALL clear TO on any STATUS write; a timeout on the same edge SHALL take priority (TO stays 1).
REQ-022 SHALL drive irq = OR over channels of (TO & ITO), combinationally from registers.
REQ-023 SHALL treat period 0 as valid: timeout on every tick.
REQ-024 SHALL keep channels fully independent; a write affects only the addressed channel.

Reset
REQ-025 SHALL, on reset_n low, asynchronously set: readdata 0, irq 0, RUN 0, TO 0, ITO 0, CONT 0, PRESCALE 0, snapshot 0, period all ones (2^CNT_W-1), counter all ones.
REQ-026 SHALL resume from the REQ-025 state after reset deassertion mid-count; no pending timeout or write survives.

Structure
REQ-027 SHALL place register offset and CONTROL/STATUS bit-position constants in shared include niosii_timer_mch_defs.
REQ-028 SHALL implement one channel (counter, prescaler, period, snapshot, status, control) as sub-module niosii_timer_mch_chan, instantiated NUM_CH times by generate.
REQ-029 SHALL keep the read mux and irq OR in the top level.

Verification
REQ-030 Ch0 period=9, PRESCALE=0, CONT=1, ITO=1, START -> TO/irq set every 10 clocks; STATUS write clears irq 1 cycle later.
REQ-031 Ch1 period=3, PRESCALE=4, CONT=0, START -> single timeout after 20 clocks, RUN reads 0, counter holds 3.
REQ-032 Ch0 running, write SNAP_L -> SNAP_L/SNAP_H return counter value at write edge; counter continues.
REQ-033 STATUS write on the same edge as timeout -> TO remains 1.
REQ-034 CONTROL write START|STOP -> RUN stays 0; write to channel 3 with NUM_CH=2 -> no state change, reads 0.
REQ-035 Assert reset_n mid-count with irq high -> irq, readdata 0 immediately; PERIOD reads 0xFFFF/upper bits after release.

Source files
------------

// File: rtl/niosii_timer_mch_defs.sv
// Shared register offsets and CONTROL/STATUS bit positions for the
// multi-channel interval timer.
package niosii_timer_mch_defs;

    typedef enum logic [2:0] {
        REG_STATUS   = 3'd0,
        REG_CONTROL  = 3'd1,
        REG_PERIOD_L = 3'd2,
        REG_PERIOD_H = 3'd3,
        REG_SNAP_L   = 3'd4,
        REG_SNAP_H   = 3'd5,
        REG_PRESCALE = 3'd6,
        REG_IRQ_PEND = 3'd7
    } reg_off_e;

    localparam int ST_TO    = 0;
    localparam int ST_RUN   = 1;
    localparam int CT_ITO   = 0;
    localparam int CT_CONT  = 1;
    localparam int CT_START = 2;
    localparam int CT_STOP  = 3;

endpackage

// File: rtl/niosii_timer_mch_chan.sv
// One timer channel: prescaler, down counter, period, snapshot, status and
// control state. Register reads are muxed in the top level.
module niosii_timer_mch_chan
    import niosii_timer_mch_defs::*;
#(
    parameter int CNT_W = 32,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  reg_off_e         wr_off,
    input  logic [15:0]      wdata,
    output logic             run,
    output logic             to,
    output logic             ito,
    output logic             cont,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] snap,
    output logic [PRE_W-1:0] prescale
);

    logic             run_q, run_d, to_q, to_d, ito_q, ito_d, cont_q, cont_d;
    logic             load_q, load_d;
    logic [CNT_W-1:0] period_q, period_d, count_q, count_d, snap_q, snap_d;
    logic [PRE_W-1:0] prescale_q, prescale_d, pcnt_q, pcnt_d;
    logic             tick, timeout;

    always_comb begin
        run_d      = run_q;
        to_d       = to_q;
        ito_d      = ito_q;
        cont_d     = cont_q;
        load_d     = 1'b0;
        period_d   = period_q;
        count_d    = count_q;
        snap_d     = snap_q;
        prescale_d = prescale_q;

        tick    = run_q && (pcnt_q == prescale_q);
        timeout = tick && (count_q == '0);

        pcnt_d = '0;
        if (run_q && !tick)
            pcnt_d = pcnt_q + PRE_W'(1);

        // A pending period load never coincides with a tick: a period
        // write always stops the channel first.
        if (load_q)
            count_d = period_q;
        else if (tick)
            count_d = timeout ? period_q : count_q - CNT_W'(1);

        if (wr_en && wr_off == REG_STATUS)
            to_d = 1'b0;
        if (timeout) begin
            to_d = 1'b1;
            if (!cont_q)
                run_d = 1'b0;
        end

        if (wr_en) begin
            case (wr_off)
                REG_CONTROL: begin
                    ito_d  = wdata[CT_ITO];
                    cont_d = wdata[CT_CONT];
                    if (wdata[CT_STOP]) begin
                        run_d = 1'b0;
                    end else if (wdata[CT_START]) begin
                        run_d  = 1'b1;
                        pcnt_d = '0;
                    end
                end
                REG_PERIOD_L: begin
                    period_d[15:0] = wdata;
                    run_d          = 1'b0;
                    pcnt_d         = '0;
                    load_d         = 1'b1;
                end
                REG_PERIOD_H: begin
                    period_d[CNT_W-1:16] = wdata[CNT_W-17:0];
                    run_d                = 1'b0;
                    pcnt_d               = '0;
                    load_d               = 1'b1;
                end
                REG_SNAP_L, REG_SNAP_H: snap_d = count_q;
                REG_PRESCALE: begin
                    prescale_d = wdata[PRE_W-1:0];
                    pcnt_d     = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q      <= 1'b0;
            to_q       <= 1'b0;
            ito_q      <= 1'b0;
            cont_q     <= 1'b0;
            load_q     <= 1'b0;
            period_q   <= '1;
            count_q    <= '1;
            snap_q     <= '0;
            prescale_q <= '0;
            pcnt_q     <= '0;
        end else begin
            run_q      <= run_d;
            to_q       <= to_d;
            ito_q      <= ito_d;
            cont_q     <= cont_d;
            load_q     <= load_d;
            period_q   <= period_d;
            count_q    <= count_d;
            snap_q     <= snap_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
        end
    end

    assign run      = run_q;
    assign to       = to_q;
    assign ito      = ito_q;
    assign cont     = cont_q;
    assign period   = period_q;
    assign snap     = snap_q;
    assign prescale = prescale_q;

endmodule

// File: rtl/niosii_timer_mch.sv
// Multi-channel interval timer with an Avalon-MM slave port; holds the
// channel array, the registered read mux and the combined interrupt.
module niosii_timer_mch
    import niosii_timer_mch_defs::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32,
    parameter int PRE_W  = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq
);

    logic [1:0]                   ch_sel;
    reg_off_e                     off;
    logic                         wr_en;
    logic [NUM_CH-1:0]            run, to, ito, cont, pend;
    logic [NUM_CH-1:0][CNT_W-1:0] period, snap;
    logic [NUM_CH-1:0][PRE_W-1:0] prescale;
    logic [15:0]                  readdata_q, readdata_d;

    assign ch_sel = address[4:3];
    assign off    = reg_off_e'(address[2:0]);
    assign wr_en  = chipselect && !write_n;

    // Channels beyond NUM_CH have no instance, so writes to them are dropped.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        niosii_timer_mch_chan #(
            .CNT_W(CNT_W),
            .PRE_W(PRE_W)
        ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .wr_en   (wr_en && (ch_sel == 2'(g))),
            .wr_off  (off),
            .wdata   (writedata),
            .run     (run[g]),
            .to      (to[g]),
            .ito     (ito[g]),
            .cont    (cont[g]),
            .period  (period[g]),
            .snap    (snap[g]),
            .prescale(prescale[g])
        );
    end

    assign pend = to & ito;
    assign irq  = |pend;

    always_comb begin
        readdata_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == 2'(i)) begin
                case (off)
                    REG_STATUS: begin
                        readdata_d[ST_RUN] = run[i];
                        readdata_d[ST_TO]  = to[i];
                    end
                    REG_CONTROL: begin
                        readdata_d[CT_CONT] = cont[i];
                        readdata_d[CT_ITO]  = ito[i];
                    end
                    REG_PERIOD_L: readdata_d = period[i][15:0];
                    REG_PERIOD_H: readdata_d[CNT_W-17:0] = period[i][CNT_W-1:16];
                    REG_SNAP_L:   readdata_d = snap[i][15:0];
                    REG_SNAP_H:   readdata_d[CNT_W-17:0] = snap[i][CNT_W-1:16];
                    REG_PRESCALE: readdata_d[PRE_W-1:0] = prescale[i];
                    REG_IRQ_PEND: readdata_d[NUM_CH-1:0] = pend;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata_q <= '0;
        else
            readdata_q <= readdata_d;
    end

    assign readdata = readdata_q;

endmodule

// File: tb/tb_niosii_timer_mch.sv
// Directed bench for the multi-channel timer: register access, timeout
// timing, snapshot, priority corner cases and async reset.
module tb_niosii_timer_mch;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic        irq;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    niosii_timer_mch #(
        .NUM_CH(2),
        .CNT_W (32),
        .PRE_W (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // All tasks start and end on a falling edge.
    task automatic wr(input logic [1:0] ch, input logic [2:0] off, input logic [15:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = {ch, off};
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] ch, input logic [2:0] off, input logic [15:0] exp,
                      input string tag);
        address = {ch, off};
        @(negedge clk);
        chk(tag, readdata, exp);
    endtask

    initial begin
        cyc(2);
        chk("rst_rd", readdata, 16'h0);
        chk("rst_irq", {15'b0, irq}, 16'h0);
        reset_n = 1'b1;
        cyc(1);
        rd(0, 2, 16'hFFFF, "rst_per_l");
        rd(0, 3, 16'hFFFF, "rst_per_h");
        rd(0, 0, 16'h0, "rst_stat");
        rd(0, 6, 16'h0, "rst_pre");
        rd(1, 4, 16'h0, "rst_snap");

        // ch0 period 9, continuous, irq enabled: timeout every 10 clocks
        wr(0, 2, 16'd9);
        wr(0, 3, 16'd0);
        wr(0, 6, 16'd0);
        wr(0, 1, 16'h7);
        cyc(9);
        chk("irq_pre1", {15'b0, irq}, 16'h0);
        cyc(1);
        chk("irq_to1", {15'b0, irq}, 16'h1);
        wr(0, 0, 16'h0);
        chk("irq_clr", {15'b0, irq}, 16'h0);
        cyc(8);
        chk("irq_pre2", {15'b0, irq}, 16'h0);
        cyc(1);
        chk("irq_to2", {15'b0, irq}, 16'h1);
        wr(0, 0, 16'h0);
        cyc(8);
        wr(0, 0, 16'h0);                   // lands on the timeout edge
        chk("prio_irq", {15'b0, irq}, 16'h1);
        rd(0, 0, 16'h3, "prio_stat");
        wr(0, 1, 16'h8);
        rd(0, 0, 16'h1, "stop_stat");
        wr(0, 0, 16'h0);
        rd(0, 0, 16'h0, "stat_clr");

        // snapshot while running
        wr(0, 2, 16'd100);
        wr(0, 3, 16'd0);
        wr(0, 1, 16'h6);
        cyc(4);
        wr(0, 4, 16'h0);
        rd(0, 4, 16'd96, "snap_l");
        rd(0, 5, 16'd0, "snap_h");
        wr(0, 5, 16'h0);
        rd(0, 4, 16'd93, "snap_l2");
        wr(0, 1, 16'h8);

        // ch1 one-shot with prescale 4: timeout exactly 20 clocks after START
        wr(1, 2, 16'd3);
        wr(1, 3, 16'd0);
        wr(1, 6, 16'd4);
        wr(1, 1, 16'h4);
        cyc(18);
        rd(1, 0, 16'h2, "c1_run18");
        rd(1, 0, 16'h2, "c1_run19");
        rd(1, 0, 16'h1, "c1_to20");
        cyc(3);
        wr(1, 4, 16'h0);
        rd(1, 4, 16'd3, "c1_hold");
        rd(1, 6, 16'd4, "c1_pre");
        rd(0, 0, 16'h0, "c0_indep");
        rd(0, 7, 16'h0, "pend_none");
        wr(1, 1, 16'h1);
        chk("c1_irq", {15'b0, irq}, 16'h1);
        rd(0, 7, 16'h2, "pend_at0");
        rd(1, 7, 16'h2, "pend_at1");
        rd(1, 1, 16'h1, "c1_ctrl");
        wr(1, 0, 16'h0);
        chk("c1_irq_clr", {15'b0, irq}, 16'h0);

        // START|STOP together, and writes to a missing channel
        wr(0, 1, 16'hF);
        rd(0, 0, 16'h0, "ss_stat");
        rd(0, 1, 16'h3, "ss_ctrl");
        wr(3, 2, 16'h1234);
        wr(3, 1, 16'h7);
        rd(3, 2, 16'h0, "c3_per");
        rd(3, 1, 16'h0, "c3_ctrl");
        rd(3, 7, 16'h0, "c3_pend");
        rd(0, 2, 16'd100, "c0_per");
        rd(1, 2, 16'd3, "c1_per");
        chk("c3_irq", {15'b0, irq}, 16'h0);

        // async reset mid-count with irq high
        wr(0, 2, 16'd1);
        wr(0, 3, 16'd0);
        wr(0, 1, 16'h7);
        for (int i = 0; i < 50 && !irq; i++) cyc(1);
        chk("pre_rst_irq", {15'b0, irq}, 16'h1);
        rd(0, 2, 16'd1, "pre_rst_rd");
        #2 reset_n = 1'b0;
        #1;
        chk("arst_irq", {15'b0, irq}, 16'h0);
        chk("arst_rd", readdata, 16'h0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(0, 2, 16'hFFFF, "post_per_l");
        rd(0, 3, 16'hFFFF, "post_per_h");
        rd(0, 0, 16'h0, "post_stat");
        rd(0, 1, 16'h0, "post_ctrl");
        rd(1, 2, 16'hFFFF, "post_c1_per");
        cyc(5);
        chk("post_irq", {15'b0, irq}, 16'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
